// File: rtl/cpu_multicycle.sv
// Multicycle RV32I-subset core with a single unified memory port.
// Supports lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, jal.
// Anything else, including register indices >= NREGS, halts the core.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   mem_req    memory access request (fetch, load or store)
//   mem_we     1 = store, 0 = read
//   mem_addr   byte address of the access
//   mem_wdata  store data
//   mem_ready  memory completes the current access this cycle
//   mem_rdata  read data
//   pc         address of the instruction in progress
//   halted     core has stopped on an illegal instruction
module cpu_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NREGS    = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic        halted
);

    localparam int unsigned IDXW = $clog2(NREGS);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StMem,
        StWriteback,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluSlt
    } alu_op_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] a_q;    // rs1 value captured in DECODE
    logic [31:0] b_q;    // rs2 value captured in DECODE
    logic [31:0] tgt_q;  // pc + imm, branch/jump target
    logic [31:0] res_q;  // ALU result, memory address, load data or link value
    logic [31:0] regs [NREGS];

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    // Sign-extended immediates
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm;

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // Decode
    logic    is_lw, is_sw, is_alu_r, is_alu_i, is_beq, is_jal;
    alu_op_e alu_op;

    always_comb begin
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_alu_r = 1'b0;
        is_alu_i = 1'b0;
        is_beq   = 1'b0;
        is_jal   = 1'b0;
        alu_op   = AluAdd;
        case (opcode)
            OP_LOAD:   is_lw = (funct3 == 3'b010);
            OP_STORE:  is_sw = (funct3 == 3'b010);
            OP_REG: begin
                if (funct7 == 7'b0000000) begin
                    is_alu_r = 1'b1;
                    case (funct3)
                        3'b000:  alu_op = AluAdd;
                        3'b111:  alu_op = AluAnd;
                        3'b110:  alu_op = AluOr;
                        3'b010:  alu_op = AluSlt;
                        default: is_alu_r = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    is_alu_r = 1'b1;
                    alu_op   = AluSub;
                end
            end
            OP_IMM: begin
                is_alu_i = 1'b1;
                case (funct3)
                    3'b000:  alu_op = AluAdd;
                    3'b111:  alu_op = AluAnd;
                    3'b110:  alu_op = AluOr;
                    3'b010:  alu_op = AluSlt;
                    default: is_alu_i = 1'b0;
                endcase
            end
            OP_BRANCH: is_beq = (funct3 == 3'b000);
            OP_JAL:    is_jal = 1'b1;
            default:   ;
        endcase
    end

    logic uses_rs1, uses_rs2, uses_rd, idx_ok, legal_op, illegal;

    assign legal_op = is_lw | is_sw | is_alu_r | is_alu_i | is_beq | is_jal;
    assign uses_rs1 = ~is_jal;
    assign uses_rs2 = is_sw | is_beq | is_alu_r;
    assign uses_rd  = is_lw | is_alu_r | is_alu_i | is_jal;
    // Only register fields the instruction actually uses are range-checked
    assign idx_ok   = (!uses_rs1 || 32'(rs1) < NREGS) &&
                      (!uses_rs2 || 32'(rs2) < NREGS) &&
                      (!uses_rd  || 32'(rd)  < NREGS);
    assign illegal  = !legal_op || !idx_ok;

    always_comb begin
        if (is_sw) begin
            imm = imm_s;
        end else if (is_beq) begin
            imm = imm_b;
        end else if (is_jal) begin
            imm = imm_j;
        end else begin
            imm = imm_i;
        end
    end

    // Register file read, x0 hardwired to zero
    logic [31:0] rs1_val, rs2_val;

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1[IDXW-1:0]];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2[IDXW-1:0]];

    // ALU; lw/sw reuse the add path for address generation
    logic [31:0] opb, alu_out;

    always_comb begin
        opb = is_alu_r ? b_q : imm;
        case (alu_op)
            AluSub:  alu_out = a_q - opb;
            AluAnd:  alu_out = a_q & opb;
            AluOr:   alu_out = a_q | opb;
            AluSlt:  alu_out = {31'd0, $signed(a_q) < $signed(opb)};
            default: alu_out = a_q + opb;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and memory port outputs
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = b_q;
        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = illegal ? StHalt : StExecute;
            end
            StExecute: begin
                if (is_lw || is_sw) begin
                    state_d = StMem;
                end else if (is_beq) begin
                    state_d = StFetch;
                end else begin
                    state_d = StWriteback;
                end
            end
            StMem: begin
                mem_req  = 1'b1;
                mem_we   = is_sw;
                mem_addr = res_q;
                if (mem_ready) begin
                    state_d = is_sw ? StFetch : StWriteback;
                end
            end
            StWriteback: begin
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StHalt;
            end
        endcase
        // No access may be issued while reset is asserted
        if (reset) begin
            mem_req = 1'b0;
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            tgt_q <= '0;
            res_q <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state_q)
                StFetch: begin
                    if (mem_ready) begin
                        ir_q <= mem_rdata;
                    end
                end
                StDecode: begin
                    a_q   <= rs1_val;
                    b_q   <= rs2_val;
                    tgt_q <= pc_q + imm;
                end
                StExecute: begin
                    if (is_beq) begin
                        pc_q <= (a_q == b_q) ? tgt_q : pc_q + 32'd4;
                    end else if (is_jal) begin
                        pc_q  <= tgt_q;
                        res_q <= pc_q + 32'd4;
                    end else begin
                        res_q <= alu_out;
                    end
                end
                StMem: begin
                    if (mem_ready) begin
                        if (is_sw) begin
                            pc_q <= pc_q + 32'd4;
                        end else begin
                            res_q <= mem_rdata;
                        end
                    end
                end
                StWriteback: begin
                    if (rd != 5'd0) begin
                        regs[rd[IDXW-1:0]] <= res_q;
                    end
                    // jal already moved pc to its target in EXECUTE
                    if (!is_jal) begin
                        pc_q <= pc_q + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc     = pc_q;
    assign halted = (state_q == StHalt);

endmodule
